token_fsm: RTL and testbench

TOKEN_FSM -- requirements
Module: token_fsm

---
 rtl/token_pkg.sv | 26 ++
 rtl/char_class.sv | 21 ++
 rtl/token_fsm.sv | 119 +++++++++++
 tb/tb_token_fsm.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/token_pkg.sv
// Shared types and constants for the token recognizer: FSM states, character
// classes and the ASCII range bounds used by the classifier.
package token_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StId   = 2'd1,
    StNum  = 2'd2,
    StErr  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ClsOther  = 2'd0,
    ClsLetter = 2'd1,
    ClsDigit  = 2'd2
  } cls_e;

  localparam logic [7:0] ChUpperA     = 8'd65;
  localparam logic [7:0] ChUpperZ     = 8'd90;
  localparam logic [7:0] ChLowerA     = 8'd97;
  localparam logic [7:0] ChLowerZ     = 8'd122;
  localparam logic [7:0] ChDigit0     = 8'd48;
  localparam logic [7:0] ChDigit9     = 8'd57;
  localparam logic [7:0] ChUnderscore = 8'd95;

endpackage

// File: rtl/char_class.sv
// Combinational ASCII classifier: LETTER, DIGIT or OTHER, with '_' optionally
// treated as a letter.
module char_class
  import token_pkg::*;
(
  input  logic [7:0] char,
  input  logic       allow_us,
  output logic [1:0] cls
);

  always_comb begin
    cls = ClsOther;
    if ((char >= ChUpperA && char <= ChUpperZ) || (char >= ChLowerA && char <= ChLowerZ) ||
        (allow_us && char == ChUnderscore)) begin
      cls = ClsLetter;
    end else if (char >= ChDigit0 && char <= ChDigit9) begin
      cls = ClsDigit;
    end
  end

endmodule

// File: rtl/token_fsm.sv
// Identifier/number tokenizer: tracks the current token class and length,
// pulses tok_done on legal termination and counts completed identifiers.
module token_fsm
  import token_pkg::*;
#(
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned CNT_W    = 8,
  parameter bit          ALLOW_US = 1'b1,
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       char,
  input  logic             char_valid,
  output logic             is_id,
  output logic             is_num,
  output logic             err,
  output logic [LEN_W-1:0] len,
  output logic             tok_done,
  output logic [CNT_W-1:0] id_count
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   id_count_q, id_count_d;
  logic               tok_done_q, tok_done_d;
  logic [1:0]         cls_raw;
  cls_e               cls;
  logic [LEN_W:0]     len_inc;
  logic               len_fits;

  char_class u_char_class (
    .char     (char),
    .allow_us (ALLOW_US),
    .cls      (cls_raw)
  );

  assign cls = cls_e'(cls_raw);

  // One extra bit so the increment cannot wrap when MAX_LEN fills LEN_W.
  assign len_inc  = {1'b0, len_q} + (LEN_W + 1)'(1);
  assign len_fits = len_inc <= (LEN_W + 1)'(MAX_LEN);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    id_count_d = id_count_q;
    tok_done_d = 1'b0;
    if (char_valid) begin
      unique case (state_q)
        StIdle: begin
          if (cls == ClsLetter) begin
            state_d = StId;
            len_d   = LEN_W'(1);
          end else if (cls == ClsDigit) begin
            state_d = StNum;
            len_d   = LEN_W'(1);
          end
        end
        StId: begin
          if (cls == ClsOther) begin
            state_d    = StIdle;
            len_d      = '0;
            tok_done_d = 1'b1;
            id_count_d = id_count_q + CNT_W'(1);
          end else if (len_fits) begin
            len_d = len_inc[LEN_W-1:0];
          end else begin
            state_d = StErr;
            len_d   = '0;
          end
        end
        StNum: begin
          if (cls == ClsOther) begin
            state_d    = StIdle;
            len_d      = '0;
            tok_done_d = 1'b1;
          end else if (cls == ClsDigit && len_fits) begin
            len_d = len_inc[LEN_W-1:0];
          end else begin
            state_d = StErr;
            len_d   = '0;
          end
        end
        StErr: begin
          if (cls == ClsOther) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          len_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      len_q      <= '0;
      id_count_q <= '0;
      tok_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      id_count_q <= id_count_d;
      tok_done_q <= tok_done_d;
    end
  end

  assign is_id    = (state_q == StId);
  assign is_num   = (state_q == StNum);
  assign err      = (state_q == StErr);
  assign len      = len_q;
  assign tok_done = tok_done_q;
  assign id_count = id_count_q;

endmodule

// File: tb/tb_token_fsm.sv
// Scoreboard bench for token_fsm across four parameter sets: default,
// MAX_LEN=4, ALLOW_US=0 and CNT_W=2.
module tb_token_fsm;

  typedef struct packed {
    logic       is_id;
    logic       is_num;
    logic       err;
    logic [7:0] len;
    logic       done;
    logic [7:0] cnt;
  } resp_t;

  typedef struct {
    int    inst;
    string label;
    resp_t exp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst [4];
  logic       vld [4];
  logic [7:0] ch  [4];
  resp_t      act [4];

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned ML = (g == 1) ? 4 : 16;
    localparam int unsigned CW = (g == 3) ? 2 : 8;
    localparam bit          US = (g == 2) ? 1'b0 : 1'b1;
    localparam int unsigned LW = $clog2(ML + 1);
    logic          is_id, is_num, err, tok_done;
    logic [LW-1:0] len;
    logic [CW-1:0] id_count;

    token_fsm #(.MAX_LEN(ML), .CNT_W(CW), .ALLOW_US(US)) u_dut (
      .clk        (clk),
      .reset      (rst[g]),
      .char       (ch[g]),
      .char_valid (vld[g]),
      .is_id      (is_id),
      .is_num     (is_num),
      .err        (err),
      .len        (len),
      .tok_done   (tok_done),
      .id_count   (id_count)
    );

    assign act[g] = {is_id, is_num, err, 8'(len), tok_done, 8'(id_count)};
  end

  // Drive one edge on one instance and queue the response expected after it.
  task automatic st(input int inst, input bit r, input bit v, input logic [7:0] c,
                    input string lbl, input bit ei, input bit en, input bit ee,
                    input int el, input bit ed, input int ec);
    exp_t e;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      rst[k] = 1'b0;
      vld[k] = 1'b0;
    end
    rst[inst] = r;
    vld[inst] = v;
    ch[inst]  = c;
    e.inst       = inst;
    e.label      = lbl;
    e.exp.is_id  = ei;
    e.exp.is_num = en;
    e.exp.err    = ee;
    e.exp.len    = 8'(el);
    e.exp.done   = ed;
    e.exp.cnt    = 8'(ec);
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (act[e.inst] !== e.exp) begin
        errors++;
        $display("FAIL %s inst%0d: got id=%0b num=%0b err=%0b len=%0d done=%0b cnt=%0d, want id=%0b num=%0b err=%0b len=%0d done=%0b cnt=%0d",
                 e.label, e.inst, act[e.inst].is_id, act[e.inst].is_num, act[e.inst].err,
                 act[e.inst].len, act[e.inst].done, act[e.inst].cnt, e.exp.is_id,
                 e.exp.is_num, e.exp.err, e.exp.len, e.exp.done, e.exp.cnt);
      end
    end
  end

  initial begin
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      rst[k] = 1'b1;
      vld[k] = 1'b1;
      ch[k]  = "a";
    end
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      e.inst = k;
      e.label = "reset";
      e.exp = '0;
      sb.push_back(e);
    end

    // Default instance: identifier, number->error, gap hold, reset mid-token.
    st(0, 0, 1, "a", "id_a",    1, 0, 0, 1, 0, 0);
    st(0, 0, 1, "b", "id_b",    1, 0, 0, 2, 0, 0);
    st(0, 0, 1, "c", "id_c",    1, 0, 0, 3, 0, 0);
    st(0, 0, 1, "d", "id_d",    1, 0, 0, 4, 0, 0);
    st(0, 0, 1, "1", "id_1",    1, 0, 0, 5, 0, 0);
    st(0, 0, 1, "2", "id_2",    1, 0, 0, 6, 0, 0);
    st(0, 0, 1, "3", "id_3",    1, 0, 0, 7, 0, 0);
    st(0, 0, 1, "4", "id_4",    1, 0, 0, 8, 0, 0);
    st(0, 0, 1, "/", "id_end",  0, 0, 0, 0, 1, 1);
    st(0, 0, 0, "x", "gap0",    0, 0, 0, 0, 0, 1);
    st(0, 0, 1, "1", "num_1",   0, 1, 0, 1, 0, 1);
    st(0, 0, 1, "2", "num_2",   0, 1, 0, 2, 0, 1);
    st(0, 0, 1, "a", "num_err", 0, 0, 1, 0, 0, 1);
    st(0, 0, 1, "7", "err_hold",0, 0, 1, 0, 0, 1);
    st(0, 0, 1, " ", "err_end", 0, 0, 0, 0, 0, 1);
    st(0, 0, 1, "a", "gap_a",   1, 0, 0, 1, 0, 1);
    st(0, 0, 1, "b", "gap_b",   1, 0, 0, 2, 0, 1);
    for (int i = 0; i < 3; i++) st(0, 0, 0, "z", "gap_hold", 1, 0, 0, 2, 0, 1);
    st(0, 0, 1, "c", "gap_c",   1, 0, 0, 3, 0, 1);
    st(0, 0, 1, ";", "gap_end", 0, 0, 0, 0, 1, 2);
    st(0, 0, 1, "x", "rst_x",   1, 0, 0, 1, 0, 2);
    st(0, 0, 1, "y", "rst_y",   1, 0, 0, 2, 0, 2);
    st(0, 1, 1, "q", "rst_mid", 0, 0, 0, 0, 0, 0);
    st(0, 0, 1, "_", "us_id",   1, 0, 0, 1, 0, 0);
    st(0, 0, 1, "q", "us_q",    1, 0, 0, 2, 0, 0);
    st(0, 0, 1, ";", "us_end",  0, 0, 0, 0, 1, 1);
    st(0, 0, 0, "a", "us_idle", 0, 0, 0, 0, 0, 1);

    // MAX_LEN=4: exact-length legal, one over is an error, same for numbers.
    st(1, 0, 1, "a", "m4_a",    1, 0, 0, 1, 0, 0);
    st(1, 0, 1, "b", "m4_b",    1, 0, 0, 2, 0, 0);
    st(1, 0, 1, "c", "m4_c",    1, 0, 0, 3, 0, 0);
    st(1, 0, 1, "d", "m4_d",    1, 0, 0, 4, 0, 0);
    st(1, 0, 1, " ", "m4_end",  0, 0, 0, 0, 1, 1);
    st(1, 0, 1, "a", "m5_a",    1, 0, 0, 1, 0, 1);
    st(1, 0, 1, "b", "m5_b",    1, 0, 0, 2, 0, 1);
    st(1, 0, 1, "c", "m5_c",    1, 0, 0, 3, 0, 1);
    st(1, 0, 1, "d", "m5_d",    1, 0, 0, 4, 0, 1);
    st(1, 0, 1, "e", "m5_e",    0, 0, 1, 0, 0, 1);
    st(1, 0, 1, "f", "m5_f",    0, 0, 1, 0, 0, 1);
    st(1, 0, 1, " ", "m5_end",  0, 0, 0, 0, 0, 1);
    st(1, 0, 1, "1", "n5_1",    0, 1, 0, 1, 0, 1);
    st(1, 0, 1, "2", "n5_2",    0, 1, 0, 2, 0, 1);
    st(1, 0, 1, "3", "n5_3",    0, 1, 0, 3, 0, 1);
    st(1, 0, 1, "4", "n5_4",    0, 1, 0, 4, 0, 1);
    st(1, 0, 1, "5", "n5_5",    0, 0, 1, 0, 0, 1);
    st(1, 0, 1, " ", "n5_end",  0, 0, 0, 0, 0, 1);

    // ALLOW_US=0: '_' is OTHER; class boundaries around letters and digits.
    st(2, 0, 1, "_", "nu_us",   0, 0, 0, 0, 0, 0);
    st(2, 0, 1, "q", "nu_q",    1, 0, 0, 1, 0, 0);
    st(2, 0, 1, ";", "nu_end",  0, 0, 0, 0, 1, 1);
    st(2, 0, 1, "a", "nu_a",    1, 0, 0, 1, 0, 1);
    st(2, 0, 1, "_", "nu_term", 0, 0, 0, 0, 1, 2);
    st(2, 0, 1, 8'd64,  "b_at",    0, 0, 0, 0, 0, 2);
    st(2, 0, 1, 8'd91,  "b_brk",   0, 0, 0, 0, 0, 2);
    st(2, 0, 1, 8'd96,  "b_tick",  0, 0, 0, 0, 0, 2);
    st(2, 0, 1, 8'd123, "b_brace", 0, 0, 0, 0, 0, 2);
    st(2, 0, 1, 8'd58,  "b_colon", 0, 0, 0, 0, 0, 2);
    st(2, 0, 1, "A", "b_A",     1, 0, 0, 1, 0, 2);
    st(2, 0, 1, "z", "b_z",     1, 0, 0, 2, 0, 2);
    st(2, 0, 1, "0", "b_0",     1, 0, 0, 3, 0, 2);
    st(2, 0, 1, "9", "b_9",     1, 0, 0, 4, 0, 2);
    st(2, 0, 1, ".", "b_end",   0, 0, 0, 0, 1, 3);
    st(2, 0, 1, "0", "bn_0",    0, 1, 0, 1, 0, 3);
    st(2, 0, 1, "9", "bn_9",    0, 1, 0, 2, 0, 3);
    st(2, 0, 1, 8'd47, "bn_end", 0, 0, 0, 0, 1, 3);

    // CNT_W=2: identifier counter wraps after four tokens.
    for (int i = 0; i < 4; i++) begin
      st(3, 0, 1, "a", "wrap_a", 1, 0, 0, 1, 0, i);
      st(3, 0, 1, ";", "wrap_end", 0, 0, 0, 0, 1, (i + 1) % 4);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
